// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one WIDTH-bit adder between NREQ requesters. Each cycle a
//   round-robin arbiter picks one valid requester. The winner's sum,
//   carry-out and signed overflow are registered into a single response slot,
//   tagged with the winner's index. A downstream valid/ready consumer drains
//   the slot.
//
// Configuration macro:
//   ADDER_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                         (round-robin pointer held at 0)
//                            undefined -> round-robin (default)
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NREQ        requester i offers an operand pair
//   req_ready  out  NREQ        requester i's pair accepted this cycle (one-hot/zero)
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   rsp_valid  out  1           response slot full
//   rsp_ready  in   1           consumer takes the response this cycle
//   rsp_id     out  IDW         owner of the response
//   rsp_sum    out  WIDTH       (A+B) mod 2^WIDTH
//   rsp_cout   out  1           unsigned carry out
//   rsp_ovr    out  1           signed overflow
//   busy       out  1           rsp_valid | (|req_valid)
module adder_share_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 64,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovr,
    output logic                  busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          win_p0;
    logic                    found_p0;
    logic                    can_accept;
    logic                    accept;
    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic [WIDTH:0]          add_p0;
    logic signed [WIDTH-1:0] sum_p0;
    logic                    ovr_p0;
    int                      idx;

    // Unsigned add with one extra bit so the carry out falls into the MSB.
    function automatic logic [WIDTH:0] add_wrap(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovr(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // ---- stage 0: arbitration and shared adder (combinational) ----
    // Scan from the far end back toward ptr so that the last hit, which
    // overwrites the others, is the requester closest to ptr.
    always_comb begin
        win_p0   = '0;
        found_p0 = 1'b0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_p0   = IDW'(idx);
                found_p0 = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign accept     = can_accept && found_p0;

    // Gated by rst_n so no requester sees a grant while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[win_p0] = 1'b1;
        end
    end

    assign a_p0   = req_a[int'(win_p0)*WIDTH +: WIDTH];
    assign b_p0   = req_b[int'(win_p0)*WIDTH +: WIDTH];
    assign add_p0 = add_wrap(a_p0, b_p0);
    assign sum_p0 = add_p0[WIDTH-1:0];
    assign ovr_p0 = signed_ovr(a_p0, b_p0, sum_p0);

    // ---- stage 1: response slot ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The slot contents are cleared on reset as well, so a reset mid-flight
    // leaves nothing behind that could be mistaken for a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovr  <= 1'b0;
        end else if (accept) begin
            rsp_id   <= win_p0;
            rsp_sum  <= sum_p0;
            rsp_cout <= add_p0[WIDTH];
            rsp_ovr  <= ovr_p0;
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0: lowest index wins.
    assign ptr_q = '0;
`else
    // Pointer moves to just past the winner; it only advances on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            if (win_p0 == IDW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win_p0 + 1'b1;
            end
        end
    end
`endif

    assign rsp_valid = (state_q == FULL);
    assign busy      = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NREQ=4, WIDTH=64).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge.
module tb_adder_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int IDW   = 2;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovr;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_ovr  (rsp_ovr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Apply inputs, then check the combinational grant before the next rising edge.
    task automatic drive(input string tag, input logic [3:0] vld, input logic rdy,
                         input logic [3:0] exp_ready);
        req_valid = vld;
        rsp_ready = rdy;
        #1;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
    endtask

    // Advance one cycle and check the full response slot.
    task automatic step_rsp(input string tag, input logic [1:0] id, input logic [63:0] sum,
                            input logic cout, input logic ovr);
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_id"},    64'(rsp_id),    64'(id));
        chk({tag, ".rsp_sum"},   rsp_sum,        sum);
        chk({tag, ".rsp_cout"},  64'(rsp_cout),  64'(cout));
        chk({tag, ".rsp_ovr"},   64'(rsp_ovr),   64'(ovr));
    endtask

    logic [1:0]  rr_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0]  eid;
    logic [63:0] esum;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'(16 * i));

        // Reset state; grants are suppressed while reset is held.
        @(negedge clk);
        drive("rst_hold", 4'hF, 1'b1, 4'h0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_sum",   rsp_sum,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all four requesters valid: sum_i = 17*i + 1.
        for (int s = 0; s < 5; s++) begin
            eid  = FIXED ? 2'd0 : rr_ids[s];
            esum = 64'(17 * int'(eid) + 1);
            drive("rr", 4'hF, 1'b1, 4'(1 << eid));
            step_rsp("rr", eid, esum, 1'b0, 1'b0);
        end

        // Single request: carry out, no signed overflow.
        set_req(2, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        drive("single", 4'b0100, 1'b1, 4'b0100);
        step_rsp("single", 2'd2, 64'h0, 1'b1, 1'b0);

        // Positive + positive overflows into the sign bit.
        set_req(2, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        drive("ovr_pos", 4'b0100, 1'b1, 4'b0100);
        step_rsp("ovr_pos", 2'd2, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Negative + negative: carry and overflow together.
        set_req(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        drive("ovr_neg", 4'b0100, 1'b1, 4'b0100);
        step_rsp("ovr_neg", 2'd2, 64'h0, 1'b1, 1'b1);

        // Drain: slot empties, nothing pending.
        drive("drain", 4'b0000, 1'b1, 4'b0000);
        @(negedge clk);
        chk("drain.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("drain.busy",      64'(busy),      64'd0);

        // Backpressure: slot holds, req 1 waits, then goes in the same cycle ready returns.
        set_req(1, 64'd5, 64'd7);
        drive("bp_fill", 4'b0010, 1'b1, 4'b0010);
        step_rsp("bp_fill", 2'd1, 64'd12, 1'b0, 1'b0);
        set_req(1, 64'd100, 64'd23);
        for (int c = 0; c < 3; c++) begin
            drive("bp_hold", 4'b0010, 1'b0, 4'b0000);
            step_rsp("bp_hold", 2'd1, 64'd12, 1'b0, 1'b0);
            chk("bp_hold.busy", 64'(busy), 64'd1);
        end
        drive("bp_release", 4'b0010, 1'b1, 4'b0010);
        step_rsp("bp_release", 2'd1, 64'd123, 1'b0, 1'b0);

        // Wrap: after a grant to 3, requester 0 is served before 3 again.
        set_req(3, 64'd9, 64'd9);
        set_req(0, 64'd2, 64'd3);
        drive("wrap3", 4'b1000, 1'b1, 4'b1000);
        step_rsp("wrap3", 2'd3, 64'd18, 1'b0, 1'b0);
        drive("wrap0", 4'b1001, 1'b1, 4'b0001);
        step_rsp("wrap0", 2'd0, 64'd5, 1'b0, 1'b0);
        eid  = FIXED ? 2'd0 : 2'd3;
        esum = FIXED ? 64'd5 : 64'd18;
        drive("wrap3b", 4'b1001, 1'b1, 4'(1 << eid));
        step_rsp("wrap3b", eid, esum, 1'b0, 1'b0);
        drive("wrap0b", 4'b1001, 1'b1, 4'b0001);
        step_rsp("wrap0b", 2'd0, 64'd5, 1'b0, 1'b0);

        // Mid-stream async reset with a full slot and nonzero contents.
        set_req(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2);
        drive("pre_rst", 4'b1000, 1'b1, 4'b1000);
        step_rsp("pre_rst", 2'd3, 64'h1, 1'b1, 1'b0);
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst.rsp_id",    64'(rsp_id),    64'd0);
        chk("arst.rsp_sum",   rsp_sum,        64'd0);
        chk("arst.rsp_cout",  64'(rsp_cout),  64'd0);
        chk("arst.rsp_ovr",   64'(rsp_ovr),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'(16 * i));

        // First grant after release goes to requester 0.
        drive("post_rst", 4'hF, 1'b1, 4'b0001);
        step_rsp("post_rst", 2'd0, 64'd1, 1'b0, 1'b0);
        req_valid = '0;
        @(negedge clk);
        chk("final.rsp_valid", 64'(rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
